// File: rtl/dh_exp_arbiter.sv
// dh_exp_arbiter
//   Round-robin scheduler sharing one exponentiation engine between two
//   requesters. Requests enter through valid/ready. The engine is driven with a
//   level start held until done. Results go back through a one-cycle rspN_valid
//   pulse to the requester that owns the operation.
//
//   Build option: define DH_EXP_TIMEOUT_EN to enable the RUN watchdog. After
//   TIMEOUT_CYCLES cycles in RUN without eng_done, the block returns
//   rsp_err=1 and rsp_result=0.
//
//   Ports
//     clk, rst                   clock, synchronous active-high reset
//     reqN_valid/base/exp/ready  request handshake (N = 0, 1)
//     rspN_valid                 one-cycle result pulse to the owner
//     rsp_result, rsp_err        result and timeout flag, qualified by rspN_valid
//     busy                       high whenever the FSM is not idle
//     eng_start/base/exp         engine control and operands
//     eng_result, eng_done       engine outputs
//
//   state   | meaning
//   IDLE    | waiting for a request; arbitrates and latches operands
//   RUN     | eng_start held high; waiting for eng_done (or watchdog)
//   RELEASE | eng_start low one cycle to clear engine; response pulse out
module dh_exp_arbiter #(
  parameter int WIDTH          = 32,
  parameter int RES_W          = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_base,
  input  logic [WIDTH-1:0] req0_exp,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_base,
  input  logic [WIDTH-1:0] req1_exp,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic             eng_start,
  output logic [WIDTH-1:0] eng_base,
  output logic [WIDTH-1:0] eng_exp,
  input  logic [RES_W-1:0] eng_result,
  input  logic             eng_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0] state;
  logic       last;   // requester granted most recently (1 after reset, so req0 wins first tie)
  logic       owner;  // requester that owns the operation in flight
  logic       grant;

  // On a tie, grant the requester that was not granted last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last;
    else                          grant = req1_valid;
  end

  assign busy = (state != S_IDLE);

`ifdef DH_EXP_TIMEOUT_EN
  logic [31:0] to_cnt;
`else
  // The watchdog limit only matters in timeout builds.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      eng_start  <= 1'b0;
      eng_base   <= '0;
      eng_exp    <= '0;
`ifdef DH_EXP_TIMEOUT_EN
      rsp_err    <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            state      <= S_RUN;
            eng_start  <= 1'b1;
            owner      <= grant;
            last       <= grant;
            eng_base   <= grant ? req1_base : req0_base;
            eng_exp    <= grant ? req1_exp  : req0_exp;
            req0_ready <= ~grant;
            req1_ready <= grant;
`ifdef DH_EXP_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        S_RUN: begin
          if (eng_done) begin
            state      <= S_RELEASE;
            eng_start  <= 1'b0;
            rsp_result <= eng_result;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
`ifdef DH_EXP_TIMEOUT_EN
            rsp_err    <= 1'b0;
          end else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            // to_cnt is 0 in the first RUN cycle, so this fires after
            // TIMEOUT_CYCLES cycles in RUN; eng_done in the same cycle wins above.
            state      <= S_RELEASE;
            eng_start  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
          end else begin
            to_cnt     <= to_cnt + 32'd1;
`endif
          end
        end
        S_RELEASE: state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          eng_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dh_exp_arbiter.sv
module tb_dh_exp_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_base, req0_exp, req1_base, req1_exp;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [63:0] rsp_result;
  logic        rsp_err, busy, eng_start;
  logic [31:0] eng_base, eng_exp;
  logic [63:0] eng_result;
  logic        eng_done;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          id;
    logic [63:0] res;
    bit          err;
  } exp_t;
  exp_t q[$];

  int eng_lat  = 4;
  bit eng_hang = 1'b0;
  int ecnt;

  always #5 clk = ~clk;

  dh_exp_arbiter #(.WIDTH(32), .RES_W(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_base(req0_base), .req0_exp(req0_exp), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_base(req1_base), .req1_exp(req1_exp), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_base(eng_base), .eng_exp(eng_exp),
    .eng_result(eng_result), .eng_done(eng_done)
  );

  // Behavioural engine: level start, done held until start drops.
  function automatic logic [63:0] pw(input logic [31:0] b, input logic [31:0] e);
    logic [63:0] r = 64'd1;
    for (int i = 0; i < int'(e); i++) r = r * 64'(b);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst || !eng_start) begin
      ecnt     <= 0;
      eng_done <= 1'b0;
    end else if (!eng_hang) begin
      if (ecnt == eng_lat) begin
        eng_done   <= 1'b1;
        eng_result <= pw(eng_base, eng_exp);
      end else begin
        ecnt <= ecnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %0d, expected %0d", name, got, want);
    else passed++;
  endtask

  // Monitor: pops the expected response whenever the DUT presents one.
  always begin
    @(posedge clk);
    #1;
    if (rsp0_valid || rsp1_valid) begin
      if (rsp0_valid && rsp1_valid) check("rsp_both_valid", 64'd1, 64'd0);
      if (q.size() == 0) begin
        check("rsp_unexpected", {63'd0, rsp1_valid}, 64'd2);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_owner",  {63'd0, rsp1_valid}, {63'd0, e.id});
        check("rsp_result", rsp_result, e.res);
        check("rsp_err",    {63'd0, rsp_err}, {63'd0, e.err});
      end
    end
  end

  task automatic wait_ready(input bit id);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(id ? req1_ready : req0_ready) && n < 50);
    check(id ? "req1_ready" : "req0_ready", {63'd0, (id ? req1_ready : req0_ready)}, 64'd1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(rsp0_valid || rsp1_valid) && n < 200);
    check("rsp_seen", {63'd0, (rsp0_valid || rsp1_valid)}, 64'd1);
  endtask

  task automatic push(input bit id, input logic [63:0] res, input bit err);
    exp_t e;
    e.id = id; e.res = res; e.err = err;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_base = 0; req0_exp = 0; req1_base = 0; req1_exp = 0;
    eng_result = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_eng_start", {63'd0, eng_start}, 64'd0);
    check("rst_busy",      {63'd0, busy}, 64'd0);
    check("rst_ready",     {62'd0, req1_ready, req0_ready}, 64'd0);
    check("rst_rsp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    check("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_eng_ops",   {eng_base, eng_exp}, 64'd0);
    rst = 1'b0;

    // Tie after reset: req0 first (2^10), then req1 (5^3).
    req0_valid = 1; req0_base = 2; req0_exp = 10;
    req1_valid = 1; req1_base = 5; req1_exp = 3;
    push(0, 64'd1024, 0); push(1, 64'd125, 0);
    @(posedge clk); #1;
    check("tie1_ready0", {63'd0, req0_ready}, 64'd1);
    check("tie1_ready1", {63'd0, req1_ready}, 64'd0);
    req0_valid = 0;
    wait_rsp();
    wait_ready(1);
    req1_valid = 0;
    wait_rsp();
    @(posedge clk); #1;

    // Single request req0 3^5 with exact T+1 timing and release behaviour.
    req0_valid = 1; req0_base = 3; req0_exp = 5;
    push(0, 64'd243, 0);
    @(posedge clk); #1;
    check("single_ready_t1", {63'd0, req0_ready}, 64'd1);
    check("single_start_t1", {63'd0, eng_start}, 64'd1);
    check("single_busy",     {63'd0, busy}, 64'd1);
    req0_valid = 0;
    @(posedge clk); #1;
    check("single_ready_pulse", {63'd0, req0_ready}, 64'd0);
    wait_rsp();
    check("release_start_low", {63'd0, eng_start}, 64'd0);
    check("release_busy",      {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("idle_busy",       {63'd0, busy}, 64'd0);
    check("rsp_pulse_width", {63'd0, rsp0_valid}, 64'd0);
    check("idle_start_low",  {63'd0, eng_start}, 64'd0);

    // Tie after req0 was last granted: req1 (3^3) goes first, then req0 (2^3).
    req0_valid = 1; req0_base = 2; req0_exp = 3;
    req1_valid = 1; req1_base = 3; req1_exp = 3;
    push(1, 64'd27, 0); push(0, 64'd8, 0);
    @(posedge clk); #1;
    check("tie2_ready1", {63'd0, req1_ready}, 64'd1);
    check("tie2_ready0", {63'd0, req0_ready}, 64'd0);
    req1_valid = 0;
    wait_rsp();
    wait_ready(0);
    req0_valid = 0;
    wait_rsp();
    @(posedge clk); #1;

    // Reset four cycles into RUN: no response, start drops, then req1 7^2.
    eng_lat = 20;
    req0_valid = 1; req0_base = 4; req0_exp = 4;
    wait_ready(0);
    req0_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_start", {63'd0, eng_start}, 64'd0);
    check("midrst_busy",  {63'd0, busy}, 64'd0);
    rst = 1'b0;
    eng_lat = 4;
    req1_valid = 1; req1_base = 7; req1_exp = 2;
    push(1, 64'd49, 0);
    wait_ready(1);
    req1_valid = 0;
    wait_rsp();
    @(posedge clk); #1;

    // Operand hold: base changes after acceptance must not matter.
    req0_valid = 1; req0_base = 3; req0_exp = 2;
    push(0, 64'd9, 0);
    wait_ready(0);
    req0_valid = 0; req0_base = 9;
    check("hold_eng_base", {32'd0, eng_base}, 64'd3);
    wait_rsp();
    @(posedge clk); #1;

`ifdef DH_EXP_TIMEOUT_EN
    // Engine never finishes: watchdog returns err=1, result 0.
    eng_hang = 1'b1;
    req0_valid = 1; req0_base = 2; req0_exp = 2;
    push(0, 64'd0, 1);
    wait_ready(0);
    req0_valid = 0;
    wait_rsp();
    @(posedge clk); #1;
    check("timeout_busy", {63'd0, busy}, 64'd0);
    eng_hang = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
